// File: rtl/seg_frame_rx.sv
// seg_frame_rx
//   Receiver for the 16-bit latch-framed 7-segment display stream. It deserialises
//   each frame, checks the framing and the select/reserved bits, identifies the
//   addressed digit and decodes the segment pattern back to a BCD nibble.
//
//   Parameter
//     SEG_ACTIVE_LOW : 1 = segment bits are active-low on the wire (inverted before decode)
//   Ports
//     clk        system clock, all logic on posedge
//     rst        synchronous active-high reset
//     bit_en     sample strobe for segData/latch
//     segData    serial data bit
//     latch      frame marker, 0 only on the last bit (bit 15) of a frame
//     seg_raw    last accepted segment pattern {g,f,e,d,c,b,a}, polarity corrected
//     digit_idx  digit addressed by the last accepted frame
//     bcd_out    {d3,d2,d1,d0}; 4'hF where the pattern is not a decimal digit
//     frame_vld  1-cycle pulse per accepted frame
//     scan_done  1-cycle pulse when digit 3 completes a 0,1,2,3 scan
//     frame_err  1-cycle pulse per discarded frame
module seg_frame_rx #(
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_en,
    input  logic        segData,
    input  logic        latch,
    output logic [6:0]  seg_raw,
    output logic [1:0]  digit_idx,
    output logic [15:0] bcd_out,
    output logic        frame_vld,
    output logic        scan_done,
    output logic        frame_err
);

    typedef enum logic [1:0] {S_SYNC, S_RX, S_CHECK} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [15:0] sr_reg;
    logic        shift_en;
    logic        ferr_now;

    // Frame checks produce results in a staging register; the outputs follow one
    // cycle later. Framing errors go through the same stage, so a framing error
    // and a checked frame can never surface in the same cycle.
    logic        p_vld_reg, p_err_reg;
    logic [6:0]  p_seg_reg;
    logic [1:0]  p_idx_reg;
    logic [3:0]  p_nib_reg;

    logic [6:0]  seg_raw_reg;
    logic [1:0]  digit_idx_reg;
    logic        frame_vld_reg, frame_err_reg, scan_done_reg;
    logic [2:0]  mask_reg;
    logic [3:0]  nib_reg [4];

    // Next-state / control
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shift_en   = 1'b0;
        ferr_now   = 1'b0;
        case (state_reg)
            S_SYNC: begin
                if (bit_en && !latch) begin
                    state_next = S_RX;
                    cnt_next   = 4'd0;
                end
            end
            S_RX: begin
                if (bit_en) begin
                    shift_en = 1'b1;
                    if (!latch) begin
                        cnt_next = 4'd0;
                        if (cnt_reg == 4'd15) begin
                            state_next = S_CHECK;
                        end else begin
                            // Early end marker: drop the frame, treat this bit as
                            // the end of a frame so the next bit is bit 0.
                            ferr_now = 1'b1;
                        end
                    end else if (cnt_reg == 4'd15) begin
                        ferr_now   = 1'b1;
                        cnt_next   = 4'd0;
                        state_next = S_SYNC;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end
            end
            S_CHECK: begin
                state_next = S_RX;
                cnt_next   = 4'd0;
                // A bit arriving here is bit 0 of the next frame. A latch=0 bit
                // here simply re-aligns the frame start.
                if (bit_en) begin
                    shift_en = 1'b1;
                    cnt_next = latch ? 4'd1 : 4'd0;
                end
            end
            default: begin
                state_next = S_SYNC;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Decode of the completed frame held in the shift register.
    // Wire order is MSB-first low byte, then MSB-first high byte.
    logic [15:0] data;
    logic [6:0]  seg_fix;
    logic        sel_ok;
    logic [1:0]  idx;
    logic [3:0]  nib;

    always_comb begin
        data    = {sr_reg[7:0], sr_reg[15:8]};
        seg_fix = {data[14], data[10], data[4], data[2], data[12], data[15], data[13]}
                  ^ {7{SEG_ACTIVE_LOW}};
        sel_ok  = (({data[3], data[1], data[0]} == 3'b001) ||
                   ({data[3], data[1], data[0]} == 3'b010) ||
                   ({data[3], data[1], data[0]} == 3'b100)) &&
                  !(data[7] && !data[3]) &&
                  !(data[5] || data[6] || data[8] || data[9] || data[11]);
        idx = 2'd0;
        if (data[1])      idx = 2'd3;
        else if (data[3]) idx = data[7] ? 2'd2 : 2'd1;
        case (seg_fix)
            7'h3F:   nib = 4'd0;
            7'h06:   nib = 4'd1;
            7'h5B:   nib = 4'd2;
            7'h4F:   nib = 4'd3;
            7'h66:   nib = 4'd4;
            7'h6D:   nib = 4'd5;
            7'h7D:   nib = 4'd6;
            7'h07:   nib = 4'd7;
            7'h7F:   nib = 4'd8;
            7'h6F:   nib = 4'd9;
            default: nib = 4'hF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_SYNC;
            cnt_reg       <= 4'd0;
            sr_reg        <= 16'd0;
            p_vld_reg     <= 1'b0;
            p_err_reg     <= 1'b0;
            p_seg_reg     <= 7'd0;
            p_idx_reg     <= 2'd0;
            p_nib_reg     <= 4'hF;
            seg_raw_reg   <= 7'd0;
            digit_idx_reg <= 2'd0;
            frame_vld_reg <= 1'b0;
            frame_err_reg <= 1'b0;
            scan_done_reg <= 1'b0;
            mask_reg      <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (shift_en) begin
                sr_reg <= {sr_reg[14:0], segData};
            end
            p_vld_reg <= (state_reg == S_CHECK) && sel_ok;
            p_err_reg <= ferr_now || ((state_reg == S_CHECK) && !sel_ok);
            p_seg_reg <= seg_fix;
            p_idx_reg <= idx;
            p_nib_reg <= nib;

            frame_vld_reg <= p_vld_reg;
            frame_err_reg <= p_err_reg;
            scan_done_reg <= 1'b0;
            if (p_vld_reg) begin
                seg_raw_reg   <= p_seg_reg;
                digit_idx_reg <= p_idx_reg;
                if (p_idx_reg == 2'd3) begin
                    scan_done_reg <= &mask_reg;
                    mask_reg      <= 3'd0;
                end else begin
                    mask_reg <= mask_reg | (3'b001 << p_idx_reg);
                end
            end
        end
    end

    // One nibble register per digit; only the addressed one is written.
    for (genvar gi = 0; gi < 4; gi++) begin : g_nib
        always_ff @(posedge clk) begin
            if (rst) begin
                nib_reg[gi] <= 4'hF;
            end else if (p_vld_reg && (p_idx_reg == 2'(gi))) begin
                nib_reg[gi] <= p_nib_reg;
            end
        end
        assign bcd_out[gi*4 +: 4] = nib_reg[gi];
    end

    assign seg_raw   = seg_raw_reg;
    assign digit_idx = digit_idx_reg;
    assign frame_vld = frame_vld_reg;
    assign frame_err = frame_err_reg;
    assign scan_done = scan_done_reg;

endmodule

// File: tb/tb_seg_frame_rx.sv
// Testbench for seg_frame_rx: two instances share the serial stream, one with
// active-high segments and one with active-low segments.
module tb_seg_frame_rx;

    logic        clk = 1'b0;
    logic        rst, bit_en, segData, latch;
    logic [6:0]  seg_raw0, seg_raw1;
    logic [1:0]  digit_idx0, digit_idx1;
    logic [15:0] bcd_out0, bcd_out1;
    logic        frame_vld0, frame_vld1, scan_done0, scan_done1, frame_err0, frame_err1;

    always #5 clk = ~clk;

    seg_frame_rx #(.SEG_ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bit_en(bit_en), .segData(segData), .latch(latch),
        .seg_raw(seg_raw0), .digit_idx(digit_idx0), .bcd_out(bcd_out0),
        .frame_vld(frame_vld0), .scan_done(scan_done0), .frame_err(frame_err0)
    );

    seg_frame_rx #(.SEG_ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .rst(rst), .bit_en(bit_en), .segData(segData), .latch(latch),
        .seg_raw(seg_raw1), .digit_idx(digit_idx1), .bcd_out(bcd_out1),
        .frame_vld(frame_vld1), .scan_done(scan_done1), .frame_err(frame_err1)
    );

    // Pulse counters, sampled on the falling edge.
    int c_vld0 = 0, c_err0 = 0, c_scan0 = 0;
    int c_vld1 = 0, c_err1 = 0, c_scan1 = 0;
    always @(negedge clk) begin
        if (frame_vld0) c_vld0++;
        if (frame_err0) c_err0++;
        if (scan_done0) c_scan0++;
        if (frame_vld1) c_vld1++;
        if (frame_err1) c_err1++;
        if (scan_done1) c_scan1++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Encoder: places segments {g..a} and digit-select bits in the 16-bit frame.
    function automatic logic [15:0] make_data(input logic [6:0] seg, input logic [1:0] idx,
                                              input logic inv);
        logic [15:0] d;
        logic [6:0]  s;
        s = inv ? ~seg : seg;
        d = 16'd0;
        d[13] = s[0]; d[15] = s[1]; d[12] = s[2]; d[2] = s[3];
        d[4]  = s[4]; d[10] = s[5]; d[14] = s[6];
        case (idx)
            2'd0: d[0] = 1'b1;
            2'd1: d[3] = 1'b1;
            2'd2: begin d[3] = 1'b1; d[7] = 1'b1; end
            default: d[1] = 1'b1;
        endcase
        return d;
    endfunction

    function automatic logic wire_bit(input logic [15:0] d, input int k);
        return (k < 8) ? d[7-k] : d[23-k];
    endfunction

    // Inputs change just after the falling edge; the DUT samples on the next rising edge.
    task automatic send_bit(input logic d, input logic l, input logic en);
        segData = d;
        latch   = l;
        bit_en  = en;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [15:0] d, input bit toggle);
        for (int k = 0; k < 16; k++) begin
            send_bit(wire_bit(d, k), (k != 15), 1'b1);
            if (toggle) send_bit(1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0, 1'b1, 1'b0);
    endtask

    typedef struct {
        logic [6:0]  seg;
        logic [1:0]  idx;
        logic [15:0] xmask;
        logic        vld;
        logic        err;
        logic        scan;
        logic [15:0] bcd;
        logic [6:0]  seg_exp;
        logic [1:0]  idx_exp;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int v0, e0, s0, v1, e1, s1;
        logic [15:0] d;

        vecs[0]  = '{7'h07, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h4327, 7'h07, 2'd0};
        vecs[1]  = '{7'h1F, 2'd2, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h4F27, 7'h1F, 2'd2};
        vecs[2]  = '{7'h6F, 2'd1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h4F97, 7'h6F, 2'd1};
        vecs[3]  = '{7'h3F, 2'd3, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h4F97, 7'h6F, 2'd1};
        vecs[4]  = '{7'h6D, 2'd2, 16'h0100, 1'b0, 1'b1, 1'b0, 16'h4F97, 7'h6F, 2'd1};
        vecs[5]  = '{7'h7D, 2'd1, 16'h0020, 1'b0, 1'b1, 1'b0, 16'h4F97, 7'h6F, 2'd1};
        vecs[6]  = '{7'h06, 2'd0, 16'h0080, 1'b0, 1'b1, 1'b0, 16'h4F97, 7'h6F, 2'd1};
        vecs[7]  = '{7'h7F, 2'd3, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h8F97, 7'h7F, 2'd3};
        vecs[8]  = '{7'h5B, 2'd3, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h2F97, 7'h5B, 2'd3};
        vecs[9]  = '{7'h00, 2'd1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h2FF7, 7'h00, 2'd1};
        vecs[10] = '{7'h06, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h2FF1, 7'h06, 2'd0};
        vecs[11] = '{7'h4F, 2'd2, 16'h0800, 1'b0, 1'b1, 1'b0, 16'h2FF1, 7'h06, 2'd0};
        vecs[12] = '{7'h4F, 2'd2, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h23F1, 7'h4F, 2'd2};
        vecs[13] = '{7'h3F, 2'd0, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h23F1, 7'h4F, 2'd2};

        // Reset
        rst = 1'b1; bit_en = 1'b0; segData = 1'b0; latch = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(1);
        check("reset bcd_out", 32'(bcd_out0), 32'hFFFF);
        check("reset seg_raw", 32'(seg_raw0), 32'h0);
        check("reset digit_idx", 32'(digit_idx0), 32'h0);
        check("reset pulses", 32'(c_vld0 + c_err0 + c_scan0), 32'h0);

        // Sync: a single latch=0 bit moves SYNC -> RX
        send_bit(1'b0, 1'b0, 1'b1);

        // Four back-to-back frames, digits 0..3 showing 1,2,3,4
        v0 = c_vld0; e0 = c_err0; s0 = c_scan0;
        send_frame(make_data(7'h06, 2'd0, 1'b0), 1'b0);
        send_frame(make_data(7'h5B, 2'd1, 1'b0), 1'b0);
        send_frame(make_data(7'h4F, 2'd2, 1'b0), 1'b0);
        send_frame(make_data(7'h66, 2'd3, 1'b0), 1'b0);
        idle(4);
        $display("scan 1234: bcd=%h vld=%0d scan=%0d err=%0d", bcd_out0,
                 c_vld0 - v0, c_scan0 - s0, c_err0 - e0);
        check("scan bcd_out", 32'(bcd_out0), 32'h4321);
        check("scan vld count", 32'(c_vld0 - v0), 32'd4);
        check("scan scan_done count", 32'(c_scan0 - s0), 32'd1);
        check("scan err count", 32'(c_err0 - e0), 32'd0);
        check("scan seg_raw", 32'(seg_raw0), 32'h66);
        check("scan digit_idx", 32'(digit_idx0), 32'd3);

        // Table of single frames: pulse latency, pulses and updated outputs
        for (int i = 0; i < 14; i++) begin
            d = make_data(vecs[i].seg, vecs[i].idx, 1'b0) ^ vecs[i].xmask;
            send_frame(d, 1'b0);
            idle(1);
            check($sformatf("vec%0d early pulse", i), 32'({frame_vld0, frame_err0}), 32'h0);
            idle(1);
            check($sformatf("vec%0d frame_vld", i), 32'(frame_vld0), 32'(vecs[i].vld));
            check($sformatf("vec%0d frame_err", i), 32'(frame_err0), 32'(vecs[i].err));
            check($sformatf("vec%0d scan_done", i), 32'(scan_done0), 32'(vecs[i].scan));
            check($sformatf("vec%0d bcd_out", i), 32'(bcd_out0), 32'(vecs[i].bcd));
            check($sformatf("vec%0d seg_raw", i), 32'(seg_raw0), 32'(vecs[i].seg_exp));
            check($sformatf("vec%0d digit_idx", i), 32'(digit_idx0), 32'(vecs[i].idx_exp));
            $display("vec%0d: data=%h vld=%b err=%b scan=%b bcd=%h seg=%h idx=%0d", i, d,
                     frame_vld0, frame_err0, scan_done0, bcd_out0, seg_raw0, digit_idx0);
            idle(1);
        end

        // Early latch=0 on bit 9, then a good frame
        v0 = c_vld0; e0 = c_err0;
        d = make_data(7'h66, 2'd0, 1'b0);
        for (int k = 0; k < 10; k++) send_bit(wire_bit(d, k), (k != 9), 1'b1);
        idle(3);
        check("early latch err count", 32'(c_err0 - e0), 32'd1);
        check("early latch bcd held", 32'(bcd_out0), 32'h23F1);
        send_frame(d, 1'b0);
        idle(3);
        check("after resync vld count", 32'(c_vld0 - v0), 32'd1);
        check("after resync bcd", 32'(bcd_out0), 32'h23F4);
        $display("early latch: err=%0d vld=%0d bcd=%h", c_err0 - e0, c_vld0 - v0, bcd_out0);

        // 16 bits with latch=1 -> error and SYNC; junk ignored until latch=0
        v0 = c_vld0; e0 = c_err0;
        for (int k = 0; k < 16; k++) send_bit(1'b1, 1'b1, 1'b1);
        idle(3);
        check("no latch err count", 32'(c_err0 - e0), 32'd1);
        check("no latch bcd held", 32'(bcd_out0), 32'h23F4);
        e0 = c_err0;
        for (int k = 0; k < 5; k++) send_bit(1'b1, 1'b1, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        send_frame(make_data(7'h6D, 2'd1, 1'b0), 1'b0);
        idle(3);
        check("sync junk err count", 32'(c_err0 - e0), 32'd0);
        check("sync frame vld count", 32'(c_vld0 - v0), 32'd1);
        check("sync frame bcd", 32'(bcd_out0), 32'h2354);
        $display("resync from SYNC: vld=%0d err=%0d bcd=%h", c_vld0 - v0, c_err0 - e0, bcd_out0);

        // Reset at bit 8 of a frame, then active-low '8' frame with bit_en toggling
        d = make_data(7'h3F, 2'd2, 1'b0);
        for (int k = 0; k < 8; k++) send_bit(wire_bit(d, k), 1'b1, 1'b1);
        v0 = c_vld0; e0 = c_err0; s0 = c_scan0;
        v1 = c_vld1; e1 = c_err1; s1 = c_scan1;
        rst = 1'b1;
        send_bit(wire_bit(d, 8), 1'b1, 1'b1);
        rst = 1'b0;
        idle(3);
        check("mid reset pulses dut0", 32'((c_vld0 - v0) + (c_err0 - e0) + (c_scan0 - s0)), 32'd0);
        check("mid reset pulses dut1", 32'((c_vld1 - v1) + (c_err1 - e1) + (c_scan1 - s1)), 32'd0);
        check("mid reset bcd dut0", 32'(bcd_out0), 32'hFFFF);
        check("mid reset seg dut0", 32'(seg_raw0), 32'h0);
        check("mid reset bcd dut1", 32'(bcd_out1), 32'hFFFF);
        check("mid reset idx dut1", 32'(digit_idx1), 32'h0);
        send_bit(1'b0, 1'b0, 1'b1);
        send_bit(1'b0, 1'b1, 1'b0);
        send_frame(make_data(7'h7F, 2'd2, 1'b1), 1'b1);
        idle(4);
        check("active-low vld count", 32'(c_vld1 - v1), 32'd1);
        check("active-low err count", 32'(c_err1 - e1), 32'd0);
        check("active-low bcd", 32'(bcd_out1), 32'hF8FF);
        check("active-low seg_raw", 32'(seg_raw1), 32'h7F);
        check("active-low digit_idx", 32'(digit_idx1), 32'd2);
        check("active-high view bcd", 32'(bcd_out0), 32'hFFFF);
        $display("active-low 8: vld=%0d bcd=%h seg=%h idx=%0d", c_vld1 - v1, bcd_out1,
                 seg_raw1, digit_idx1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
